// File: rtl/flash_therm_decoder_if.sv
// Stream bundle for flash_therm_decoder: code in, thermometer pattern out.
// The onehot lane exists only when FLASH_THERM_ONEHOT_EN is defined.
interface flash_therm_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] therm;
    logic [3:0]  out_code;
`ifdef FLASH_THERM_ONEHOT_EN
    logic [15:0] onehot;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, therm, out_code, onehot
    );
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, therm, out_code, onehot
    );
`else
    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, therm, out_code
    );
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, therm, out_code
    );
`endif
endinterface

// File: rtl/flash_therm_decoder.sv
// 4-bit ADC code -> 16-bit thermometer decoder with skid-buffered output and sweep FSM.
// Optional onehot output lane enabled by defining FLASH_THERM_ONEHOT_EN.
module flash_therm_decoder #(
    parameter int unsigned SWEEP_FIRST = 0,
    parameter int unsigned SWEEP_LAST  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   sweep_start,
    output logic                   sweep_done,
    flash_therm_decoder_if.slave   bus
);

    if (SWEEP_FIRST > SWEEP_LAST || SWEEP_LAST > 15) begin : g_bad_sweep_range
        $error("flash_therm_decoder: need SWEEP_FIRST <= SWEEP_LAST <= 15");
    end

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_SWEEP, S_DONE} state_t;

    function automatic logic [15:0] therm_of(input logic [3:0] code);
        logic [15:0] t;
        t = '0;
        for (int unsigned k = 1; k < 16; k++) t[k] = (k <= 32'(code));
        return t;
    endfunction

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_code_q, out_code_d;
    logic [15:0] therm_q, therm_d;
    logic        skid_valid_q, skid_valid_d;
    logic [3:0]  skid_code_q, skid_code_d;
    logic        in_ready_q, in_ready_d;
    logic [3:0]  sweep_cnt_q, sweep_cnt_d;
`ifdef FLASH_THERM_ONEHOT_EN
    logic [15:0] onehot_q, onehot_d;
`endif

    logic       in_ready_w, in_fire, out_fire, sweep_push, push, sweep_done_w;
    logic [3:0] push_code;

    assign in_ready_w = in_ready_q && en && !rst;
    assign in_fire    = bus.in_valid && in_ready_w;
    assign out_fire   = out_valid_q && bus.out_ready;
    assign sweep_push = (state_q == S_SWEEP) && !skid_valid_q;
    assign push       = in_fire || sweep_push;
    assign push_code  = (state_q == S_SWEEP) ? sweep_cnt_q : bus.in_code;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_code_d   = out_code_q;
        therm_d      = therm_q;
        skid_valid_d = skid_valid_q;
        skid_code_d  = skid_code_q;
        sweep_cnt_d  = sweep_cnt_q;
        sweep_done_w = 1'b0;
`ifdef FLASH_THERM_ONEHOT_EN
        onehot_d     = onehot_q;
`endif

        // Skid drains first; a new beat bypasses it whenever the output slot frees this cycle.
        if (skid_valid_q) begin
            if (out_fire) begin
                out_code_d   = skid_code_q;
                therm_d      = therm_of(skid_code_q);
`ifdef FLASH_THERM_ONEHOT_EN
                onehot_d     = 16'b1 << skid_code_q;
`endif
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || out_fire) begin
                out_valid_d = 1'b1;
                out_code_d  = push_code;
                therm_d     = therm_of(push_code);
`ifdef FLASH_THERM_ONEHOT_EN
                onehot_d    = 16'b1 << push_code;
`endif
            end else begin
                skid_valid_d = 1'b1;
                skid_code_d  = push_code;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    state_d = S_PASS;
                end else if (sweep_start && !out_valid_q && !skid_valid_q) begin
                    state_d     = S_SWEEP;
                    sweep_cnt_d = 4'(SWEEP_FIRST);
                end
            end
            S_PASS: begin
                if (!bus.in_valid && !out_valid_q && !skid_valid_q) state_d = S_IDLE;
            end
            S_SWEEP: begin
                if (sweep_push) begin
                    if (sweep_cnt_q == 4'(SWEEP_LAST)) state_d = S_DONE;
                    else sweep_cnt_d = sweep_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // Nothing is pushed here, so the beat leaving with an empty skid is SWEEP_LAST.
                if (out_fire && !skid_valid_q) begin
                    state_d      = S_IDLE;
                    sweep_done_w = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = !skid_valid_d && (state_d == S_IDLE || state_d == S_PASS);

        if (!en) begin
            state_d      = S_IDLE;
            out_valid_d  = 1'b0;
            out_code_d   = '0;
            therm_d      = '0;
            skid_valid_d = 1'b0;
            skid_code_d  = '0;
            sweep_cnt_d  = '0;
            in_ready_d   = 1'b1;
            sweep_done_w = 1'b0;
`ifdef FLASH_THERM_ONEHOT_EN
            onehot_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            out_code_q   <= '0;
            therm_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_code_q  <= '0;
            in_ready_q   <= 1'b1;
            sweep_cnt_q  <= '0;
`ifdef FLASH_THERM_ONEHOT_EN
            onehot_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_code_q   <= out_code_d;
            therm_q      <= therm_d;
            skid_valid_q <= skid_valid_d;
            skid_code_q  <= skid_code_d;
            in_ready_q   <= in_ready_d;
            sweep_cnt_q  <= sweep_cnt_d;
`ifdef FLASH_THERM_ONEHOT_EN
            onehot_q     <= onehot_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.therm     = therm_q;
`ifdef FLASH_THERM_ONEHOT_EN
    assign bus.onehot    = onehot_q;
`endif
    assign sweep_done    = sweep_done_w && !rst;

endmodule
